// File: rtl/text_overlay_16x2_pkg.sv
// Shared constants and char_xy layout for the 16x2 text panel, common to the
// overlay renderer and the easy/hard char ROM variants.
package text_overlay_16x2_pkg;

  localparam int TEXT_COLS  = 16;
  localparam int TEXT_ROWS  = 2;
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int DEF_X0     = 192;
  localparam int DEF_Y0     = 208;
  localparam int SYNC_DELAY = 3;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       row;
    logic [3:0] col;
  } char_xy_t;

  function automatic char_xy_t pack_char_xy(input logic row, input logic [3:0] col);
    char_xy_t c;
    c.rsvd = 3'b000;
    c.row  = row;
    c.col  = col;
    return c;
  endfunction

endpackage

// File: rtl/text_overlay_16x2_if.sv
// Pixel stream, char/font ROM lookups and rendered outputs of the text overlay.
interface text_overlay_16x2_if;

  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        blink_en;
  logic [7:0]  char_xy;
  logic [6:0]  char_code;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        text_on;
  logic [11:0] rgb;
  logic        video_on_out;
  logic        hsync_out;
  logic        vsync_out;

  modport slave (
    input  pixel_x, pixel_y, video_on_in, hsync_in, vsync_in, blink_en,
    input  char_code, font_data,
    output char_xy, font_addr, text_on, rgb, video_on_out, hsync_out, vsync_out
  );

  modport master (
    output pixel_x, pixel_y, video_on_in, hsync_in, vsync_in, blink_en,
    output char_code, font_data,
    input  char_xy, font_addr, text_on, rgb, video_on_out, hsync_out, vsync_out
  );

endinterface

// File: rtl/text_overlay_16x2_sync_delay.sv
// N-deep shift of video_on/hsync/vsync so they stay aligned with the rendered pixel.
module text_sync_delay #(
  parameter int N = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic video_on_i,
  input  logic hsync_i,
  input  logic vsync_i,
  output logic video_on_o,
  output logic hsync_o,
  output logic vsync_o
);

  logic [N-1:0] video_on_q;
  logic [N-1:0] hsync_q;
  logic [N-1:0] vsync_q;

  // Syncs are active-low, so their idle/reset level is 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      video_on_q <= '0;
      hsync_q    <= '1;
      vsync_q    <= '1;
    end else begin
      video_on_q[0] <= video_on_i;
      hsync_q[0]    <= hsync_i;
      vsync_q[0]    <= vsync_i;
      for (int i = 1; i < N; i++) begin
        video_on_q[i] <= video_on_q[i-1];
        hsync_q[i]    <= hsync_q[i-1];
        vsync_q[i]    <= vsync_q[i-1];
      end
    end
  end

  assign video_on_o = video_on_q[N-1];
  assign hsync_o    = hsync_q[N-1];
  assign vsync_o    = vsync_q[N-1];

endmodule

// File: rtl/text_overlay_16x2.sv
// Three-stage pixel renderer for the 16x2 text panel: char lookup, font lookup,
// glyph bit select with optional frame-counted blink.
module text_overlay_16x2
  import text_overlay_16x2_pkg::*;
#(
  parameter int          X0         = DEF_X0,
  parameter int          Y0         = DEF_Y0,
  parameter int          SCALE_LOG2 = 1,
  parameter int          BLINK_LOG2 = 5,
  parameter logic [11:0] FG_RGB     = 12'hFFF
) (
  input  logic clk,
  input  logic reset_n,
  text_overlay_16x2_if.slave bus
);

  localparam int GROW_W  = $clog2(GLYPH_H);
  localparam int PANEL_W = (TEXT_COLS * GLYPH_W) << SCALE_LOG2;
  localparam int PANEL_H = (TEXT_ROWS * GLYPH_H) << SCALE_LOG2;
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + PANEL_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + PANEL_H);

  function automatic logic glyph_bit(input logic [7:0] row_bits, input logic [2:0] gcol);
    return row_bits[3'd7 - gcol];
  endfunction

  logic [9:0]        dx, dy, col_sh, row_sh, gcol_sh, grow_sh;
  logic              in_panel;
  logic [7:0]        char_xy_d, char_xy_q;
  logic              in_panel_p1_d, in_panel_p1_q;
  logic [2:0]        gcol_p1_d, gcol_p1_q;
  logic [GROW_W-1:0] grow_p1_d, grow_p1_q;
  logic [10:0]       font_addr_d, font_addr_q;
  logic              in_panel_p2_d, in_panel_p2_q;
  logic [2:0]        gcol_p2_d, gcol_p2_q;
  logic              text_on_d, text_on_q;
  logic [11:0]       rgb_d, rgb_q;
  logic              vsync_prev_d, vsync_prev_q;
  logic [BLINK_LOG2:0] frame_cnt_d, frame_cnt_q;

  always_comb begin
    dx       = bus.pixel_x - 10'(X0);
    dy       = bus.pixel_y - 10'(Y0);
    col_sh   = dx >> (3 + SCALE_LOG2);
    row_sh   = dy >> (4 + SCALE_LOG2);
    gcol_sh  = dx >> SCALE_LOG2;
    grow_sh  = dy >> SCALE_LOG2;
    in_panel = ({1'b0, bus.pixel_x} >= X_LO) && ({1'b0, bus.pixel_x} < X_HI) &&
               ({1'b0, bus.pixel_y} >= Y_LO) && ({1'b0, bus.pixel_y} < Y_HI) &&
               bus.video_on_in;

    // Stage 1: pixel coordinate -> char ROM address
    char_xy_d     = in_panel ? 8'(pack_char_xy(row_sh[0], col_sh[3:0])) : 8'h00;
    in_panel_p1_d = in_panel;
    gcol_p1_d     = gcol_sh[2:0];
    grow_p1_d     = grow_sh[GROW_W-1:0];

    // Stage 2: char code -> font ROM address
    font_addr_d   = {bus.char_code, grow_p1_q};
    in_panel_p2_d = in_panel_p1_q;
    gcol_p2_d     = gcol_p1_q;

    // Stage 3: glyph bit select and blink gating
    text_on_d = in_panel_p2_q & glyph_bit(bus.font_data, gcol_p2_q) &
                ~(bus.blink_en & frame_cnt_q[BLINK_LOG2]);
    rgb_d     = text_on_d ? FG_RGB : 12'h000;

    vsync_prev_d = bus.vsync_in;
    frame_cnt_d  = (vsync_prev_q & ~bus.vsync_in) ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      char_xy_q     <= '0;
      in_panel_p1_q <= 1'b0;
      gcol_p1_q     <= '0;
      grow_p1_q     <= '0;
      font_addr_q   <= '0;
      in_panel_p2_q <= 1'b0;
      gcol_p2_q     <= '0;
      text_on_q     <= 1'b0;
      rgb_q         <= '0;
      vsync_prev_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      char_xy_q     <= char_xy_d;
      in_panel_p1_q <= in_panel_p1_d;
      gcol_p1_q     <= gcol_p1_d;
      grow_p1_q     <= grow_p1_d;
      font_addr_q   <= font_addr_d;
      in_panel_p2_q <= in_panel_p2_d;
      gcol_p2_q     <= gcol_p2_d;
      text_on_q     <= text_on_d;
      rgb_q         <= rgb_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.char_xy   = char_xy_q;
  assign bus.font_addr = font_addr_q;
  assign bus.text_on   = text_on_q;
  assign bus.rgb       = rgb_q;

  text_sync_delay #(.N(SYNC_DELAY)) u_sync_delay (
    .clk        (clk),
    .reset_n    (reset_n),
    .video_on_i (bus.video_on_in),
    .hsync_i    (bus.hsync_in),
    .vsync_i    (bus.vsync_in),
    .video_on_o (bus.video_on_out),
    .hsync_o    (bus.hsync_out),
    .vsync_o    (bus.vsync_out)
  );

endmodule

// File: doc/text_overlay_16x2.md
Name: text_overlay_16x2

Overview:
- Pixel-pipeline renderer for the 16x2 on-screen text panel (difficulty banner) in the VGA Pong display.
- Sits directly downstream of the VGA sync generator and drives the character ROM.
  - Converts each pixel coordinate into a char_xy address.
  - Takes back the char_code, forms the font ROM address, selects the glyph bit, and outputs text_on/rgb aligned with delayed syncs.
- Adds an optional frame-counted blink.

Parameters:
- X0, 192, left edge of text panel (pixels)
- Y0, 208, top edge of text panel (pixels)
- SCALE_LOG2, 1, glyph magnification = 2^SCALE_LOG2 (0..2)
- BLINK_LOG2, 5, blink half-period = 2^BLINK_LOG2 frames
- FG_RGB, 12'hFFF, text colour

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- pixel_x  in  10  current pixel column from sync generator
- pixel_y  in  10  current pixel row
- video_on_in  in  1  active-video flag
- hsync_in  in  1  active-low hsync
- vsync_in  in  1  active-low vsync
- blink_en  in  1  enable blink
- char_xy  out  8  address to char ROM: {3'b000, row, col[3:0]}
- char_code  in  7  combinational ASCII code returned for char_xy
- font_addr  out  11  {char_code, glyph_row[3:0]} to 8x16 font ROM
- font_data  in  8  font ROM row; valid one clk after font_addr; bit7 = leftmost pixel
- text_on  out  1  text pixel lit
- rgb  out  12  FG_RGB when text_on, else 12'h000
- video_on_out, hsync_out, vsync_out  out  1 each  inputs delayed by 3 clks

Behaviour:
- One clock domain. Reset is synchronous, active-low (reset_n sampled on the clk rising edge).
- Reset values:
  - char_xy=0, font_addr=0, text_on=0, rgb=0, video_on_out=0.
  - hsync_out=1, vsync_out=1.
  - All internal pipeline registers=0, frame counter=0.
- Panel region:
  - W = 128<<SCALE_LOG2, H = 32<<SCALE_LOG2.
  - in_panel = X0 <= x < X0+W and Y0 <= y < Y0+H and video_on_in.
  - dx = x-X0, dy = y-Y0 (10-bit unsigned, used only when in_panel).
  - col = dx>>(3+SCALE_LOG2) [3:0]; row = dy>>(4+SCALE_LOG2) [0].
  - gcol = (dx>>SCALE_LOG2)[2:0]; grow = (dy>>SCALE_LOG2)[3:0].
- Stage 1 (edge 1):
  - Register char_xy = in_panel ? {3'b0,row,col} : 8'h00.
  - Register in_panel, gcol, grow.
  - char_code arrives combinationally from char_xy.
- Stage 2 (edge 2):
  - Register font_addr = {char_code, grow}; carry in_panel and gcol.
- Stage 3 (edge 3):
  - text_on = in_panel_d2 & font_data[7-gcol_d2] & ~(blink_en & frame_cnt[BLINK_LOG2]).
  - rgb = text_on ? FG_RGB : 0.
- Latency: pixel at input on edge N produces text_on/rgb on edge N+3. video_on/hsync/vsync use a 3-deep shift so they stay aligned.
- Blink:
  - frame_cnt is (BLINK_LOG2+1) bits, increments on each vsync_in falling edge (previous vsync_in registered) and wraps naturally.
  - Toggling blink_en acts on the next stage-3 output. It does not reset the counter.
- Boundaries:
  - x = X0+W-1 is inside the panel; x = X0+W is outside.
  - Same rule for y.
  - Out-of-panel pixels never assert text_on, regardless of font_data.
  - video_on_in=0 forces in_panel=0.
- Reset mid-frame: all stages flush to reset values on the reset edge. Valid output resumes 3 clks after reset_n returns high.
- No backpressure. Every cycle is a new pixel.

Decomposition:
- Shared package / header holds:
  - TEXT_COLS=16, TEXT_ROWS=2, GLYPH_W=8, GLYPH_H=16.
  - Default panel origin constants.
  - The char_xy field layout, so the char ROM variants (easy/hard) share it.
- One natural sub-module: text_sync_delay, a parameterised N-stage shift register for video_on/hsync/vsync. It resets sync bits to 1 and video_on to 0.
- Char ROM and font ROM stay external.

Test Plan:
- Pixel (240,208), video_on=1, char ROM returns 7'h44 -> char_xy=8'h03 after edge 1; font_addr=11'h440 after edge 2.
- Pixel (288,240), char_code=7'h48 -> char_xy=8'h16; font_addr=11'h480 (grow=0).
- Pixel (192,208), font_data=8'h80 -> text_on=1, rgb=12'hFFF exactly 3 clks later. Pixel (194,208) (gcol=1), font_data=8'h80 -> text_on=0. Pixel (193,208) -> text_on=1 (SCALE 2x).
- Boundary sweep:
  - x=447 -> char_xy=8'h0F.
  - x=448, y=272, x=191 with font_data=8'hFF -> text_on=0, char_xy=8'h00.
- BLINK_LOG2=1, blink_en=1, lit pixel held:
  - Frames 0-1 lit, frames 2-3 dark, frame 4 lit (counted on vsync falling edges).
  - blink_en=0 -> lit every frame.
- Assert reset_n=0 mid-line with lit pipeline -> next edge text_on=0, hsync_out=1, vsync_out=1, char_xy=0. Release -> first valid text_on 3 clks later.
